// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic pipeline stage: DEPTH-entry circular buffer with valid/ready handshake
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cancel,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = DATA_W + CTRL_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;

    // Explicit wrap so non-power-of-two depths keep slot order.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // in_ready comes from registered count only, so a pop never opens a slot in the same cycle.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);

    assign push = in_valid & in_ready & ~flush & ~cancel;
    assign pop  = out_valid & out_ready & ~hold & ~cancel;

    assign {head_ctrl, head_data} = mem[rd_ptr];
    assign out_data = head_data;
    assign out_ctrl = head_ctrl & {CTRL_W{out_valid}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (cancel) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_ctrl, in_data};
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - bench for pipe_stage_buf at DEPTH 2, 3 and 1
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, cancel, hold, in_valid, out_ready;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;

    logic        ir [3];
    logic        ov [3];
    logic [31:0] od [3];
    logic [15:0] oc [3];
    logic [1:0]  c0, c1;
    logic [0:0]  c2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(16), .DEPTH(2)) dut_d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cancel(cancel), .hold(hold),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]),
        .count(c0));

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(16), .DEPTH(3)) dut_d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cancel(cancel), .hold(hold),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]),
        .count(c1));

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(16), .DEPTH(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cancel(cancel), .hold(hold),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_ctrl(oc[2]),
        .count(c2));

    typedef struct {
        logic        fl, ca, ho, iv, ordy;
        logic [31:0] d;
        logic [15:0] c;
        int          ecnt;
        logic        eir, eov;
        logic [31:0] eod;
        logic [15:0] eoc;
    } vec_t;

    vec_t        tbl [$];
    int          depth_of [3] = '{2, 3, 1};
    logic [47:0] mq [3][$];

    function automatic int cnt_of(int k);
        if (k == 0) return int'(c0);
        if (k == 1) return int'(c1);
        return int'(c2);
    endfunction

    function automatic vec_t mk(logic fl, logic ca, logic ho, logic iv, logic ordy,
                                logic [31:0] d, logic [15:0] c, int ecnt, logic eir,
                                logic eov, logic [31:0] eod, logic [15:0] eoc);
        vec_t v;
        v.fl = fl; v.ca = ca; v.ho = ho; v.iv = iv; v.ordy = ordy; v.d = d; v.c = c;
        v.ecnt = ecnt; v.eir = eir; v.eov = eov; v.eod = eod; v.eoc = eoc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic ca, input logic ho, input logic iv,
                         input logic ordy, input logic [31:0] d, input logic [15:0] c);
        flush = fl; cancel = ca; hold = ho; in_valid = iv; out_ready = ordy;
        in_data = d; in_ctrl = c;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 32'h0, 16'h0);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_dut(input string tag, input int k, input int ecnt, input logic eir,
                           input logic eov, input logic [31:0] eod, input logic [15:0] eoc);
        chk({tag, "_count"}, 64'(cnt_of(k)), 64'(ecnt));
        chk({tag, "_in_ready"}, 64'(ir[k]), 64'(eir));
        chk({tag, "_out_valid"}, 64'(ov[k]), 64'(eov));
        chk({tag, "_out_data"}, 64'(od[k]), 64'(eod));
        chk({tag, "_out_ctrl"}, 64'(oc[k]), 64'(eoc));
    endtask

    initial begin
        int          nxt;
        int          maxcnt;
        int          cyc;
        logic [31:0] got [$];
        logic        acc;
        logic        psh [3];
        logic        pp [3];
        int          seed_dummy;

        seed_dummy = $urandom(32'hC0FFEE);
        do_reset();
        for (int k = 0; k < 3; k++) chk_dut($sformatf("reset_d%0d", depth_of[k]), k, 0, 1, 0, 0, 0);

        // Asynchronous reset with DEPTH=2 full, asserted between clock edges.
        drive(0, 0, 0, 1, 0, 32'h100, 16'h3); tick();
        drive(0, 0, 0, 1, 0, 32'h104, 16'h5); tick();
        chk("pre_areset_count", 64'(c0), 64'd2);
        drive(0, 0, 0, 0, 0, 32'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1 chk_dut("areset", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // DEPTH=2 directed table: fill, full+pop, flush, hold, cancel, flush+hold, drain.
        tbl.push_back(mk(0,0,0,1,0, 32'h100,16'h3,  1,1,1, 32'h100,16'h3));
        tbl.push_back(mk(0,0,0,1,0, 32'h104,16'h5,  2,0,1, 32'h100,16'h3));
        tbl.push_back(mk(0,0,0,1,0, 32'h108,16'h7,  2,0,1, 32'h100,16'h3));
        tbl.push_back(mk(0,0,0,1,1, 32'h108,16'h7,  1,1,1, 32'h104,16'h5));
        tbl.push_back(mk(0,0,0,1,1, 32'h108,16'h7,  1,1,1, 32'h108,16'h7));
        tbl.push_back(mk(1,0,0,1,1, 32'h10C,16'h9,  0,1,0, 32'h104,16'h0));
        tbl.push_back(mk(0,0,0,1,0, 32'h110,16'hB,  1,1,1, 32'h110,16'hB));
        tbl.push_back(mk(0,0,1,0,1, 32'h0,  16'h0,  1,1,1, 32'h110,16'hB));
        tbl.push_back(mk(0,0,1,1,1, 32'h114,16'hD,  2,0,1, 32'h110,16'hB));
        tbl.push_back(mk(1,0,1,1,1, 32'h0,  16'h0,  2,0,1, 32'h110,16'hB));
        tbl.push_back(mk(0,1,0,1,1, 32'h118,16'hF,  0,1,0, 32'h114,16'h0));
        tbl.push_back(mk(0,0,0,1,0, 32'h11C,16'h1,  1,1,1, 32'h11C,16'h1));
        tbl.push_back(mk(1,0,1,1,1, 32'h120,16'h2,  1,1,1, 32'h11C,16'h1));
        tbl.push_back(mk(0,0,0,0,1, 32'h0,  16'h0,  0,1,0, 32'h110,16'h0));
        tbl.push_back(mk(0,0,0,0,1, 32'h0,  16'h0,  0,1,0, 32'h110,16'h0));
        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].ca, tbl[i].ho, tbl[i].iv, tbl[i].ordy, tbl[i].d, tbl[i].c);
            tick();
            chk_dut($sformatf("vec%0d", i), 0, tbl[i].ecnt, tbl[i].eir, tbl[i].eov,
                    tbl[i].eod, tbl[i].eoc);
        end

        // DEPTH=1 behaves as a stage register; a full-cycle pop does not admit a push.
        do_reset();
        drive(0, 0, 0, 1, 0, 32'hA1, 16'h1); tick();
        chk_dut("d1_push", 2, 1, 0, 1, 32'hA1, 16'h1);
        drive(0, 0, 0, 1, 1, 32'hA2, 16'h2); tick();
        chk_dut("d1_pop_only", 2, 0, 1, 0, 32'hA1, 16'h0);
        tick();
        chk_dut("d1_push2", 2, 1, 0, 1, 32'hA2, 16'h2);
        drive(0, 0, 0, 0, 1, 32'h0, 16'h0); tick();
        chk_dut("d1_drain", 2, 0, 1, 0, 32'hA2, 16'h0);

        // DEPTH=3 wrap: values 1..7 with random out_ready must emerge in order.
        do_reset();
        nxt = 1; maxcnt = 0; cyc = 0;
        while (got.size() < 7 && cyc < 300) begin
            drive(0, 0, 0, nxt <= 7, 1'($urandom_range(0, 1)), 32'(nxt), 16'(nxt));
            #1;
            acc = in_valid & ir[1];
            if (ov[1] & out_ready) got.push_back(od[1]);
            tick();
            if (acc) nxt++;
            if (cnt_of(1) > maxcnt) maxcnt = cnt_of(1);
            cyc++;
        end
        chk("wrap_received", 64'(got.size()), 64'd7);
        foreach (got[i]) chk($sformatf("wrap_order%0d", i), 64'(got[i]), 64'(i + 1));
        chk("wrap_max_count_le3", 64'(maxcnt <= 3), 64'd1);

        // Random traffic on all three depths against a queue model.
        do_reset();
        for (int k = 0; k < 3; k++) mq[k].delete();
        for (int t = 0; t < 400; t++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom, 16'($urandom));
            for (int k = 0; k < 3; k++) begin
                psh[k] = in_valid && (mq[k].size() != depth_of[k]) && !flush && !cancel;
                pp[k]  = (mq[k].size() != 0) && out_ready && !hold && !cancel;
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                if (cancel) mq[k].delete();
                else begin
                    if (pp[k]) void'(mq[k].pop_front());
                    if (psh[k]) mq[k].push_back({in_ctrl, in_data});
                end
                chk($sformatf("rnd%0d_d%0d_count", t, depth_of[k]), 64'(cnt_of(k)), 64'(mq[k].size()));
                chk($sformatf("rnd%0d_d%0d_in_ready", t, depth_of[k]), 64'(ir[k]),
                    64'(mq[k].size() != depth_of[k]));
                if (mq[k].size() != 0) begin
                    chk($sformatf("rnd%0d_d%0d_out_data", t, depth_of[k]), 64'(od[k]), 64'(mq[k][0][31:0]));
                    chk($sformatf("rnd%0d_d%0d_out_ctrl", t, depth_of[k]), 64'(oc[k]), 64'(mq[k][0][47:32]));
                end else begin
                    chk($sformatf("rnd%0d_d%0d_out_ctrl", t, depth_of[k]), 64'(oc[k]), 64'd0);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
